// File: rtl/wordle_pkg.sv
// rtl/wordle_pkg.sv - shared widths, colour codes, FSM encoding and letter extraction for the guess scorer
package wordle_pkg;

  localparam int LETTER_W    = 8;
  localparam int WORD_LEN    = 5;
  localparam int MAX_GUESSES = 6;
  localparam int WORD_W      = LETTER_W * WORD_LEN;
  localparam int COLORS_W    = 2 * WORD_LEN;

  localparam logic [1:0] COL_GRAY   = 2'b00;
  localparam logic [1:0] COL_YELLOW = 2'b01;
  localparam logic [1:0] COL_GREEN  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Letter 0 is the leftmost character and sits in the most significant byte.
  function automatic logic [LETTER_W-1:0] get_letter(input logic [WORD_W-1:0] word, input int pos);
    return word[(WORD_LEN-1-pos)*LETTER_W +: LETTER_W];
  endfunction

endpackage

// File: rtl/wordle_letter_match.sv
// rtl/wordle_letter_match.sv - finds the lowest unused answer position holding a given guess letter
module wordle_letter_match
  import wordle_pkg::*;
(
  input  logic [LETTER_W-1:0] letter_i,
  input  logic [WORD_W-1:0]   answer_i,
  input  logic [WORD_LEN-1:0] used_i,
  output logic                hit_o,
  output logic [WORD_LEN-1:0] consumed_o
);

  // Scanning from the top down lets the lowest matching index overwrite any higher one.
  always_comb begin
    hit_o      = 1'b0;
    consumed_o = '0;
    for (int j = WORD_LEN - 1; j >= 0; j--) begin
      if (!used_i[j] && (get_letter(answer_i, j) == letter_i)) begin
        hit_o         = 1'b1;
        consumed_o    = '0;
        consumed_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wordle_guess_scorer.sv
// rtl/wordle_guess_scorer.sv - scores a latched guess against the answer: greens first, then yellows left to right
module wordle_guess_scorer
  import wordle_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [WORD_W-1:0]   guess_i,
  input  logic [WORD_W-1:0]   answer_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [COLORS_W-1:0] colors_o,
  output logic [2:0]          row_idx_o,
  output logic                win_o,
  output logic                lose_o
);

  state_e                state_q, state_d;
  logic [WORD_W-1:0]     guess_q, guess_d;
  logic [WORD_W-1:0]     answer_q, answer_d;
  logic [WORD_LEN-1:0]   green_q, green_d;
  logic [WORD_LEN-1:0]   used_q, used_d;
  logic [COLORS_W-1:0]   work_q, work_d;
  logic [2:0]            idx_q, idx_d;
  logic [COLORS_W-1:0]   colors_q, colors_d;
  logic [2:0]            row_q, row_d;
  logic                  win_q, win_d;
  logic                  lose_q, lose_d;

  logic [LETTER_W-1:0]   cur_letter;
  logic                  cur_green;
  logic                  hit;
  logic [WORD_LEN-1:0]   consumed;
  logic [2:0]            row_inc;

  always_comb begin
    cur_letter = '0;
    cur_green  = 1'b0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (idx_q == 3'(i)) begin
        cur_letter = get_letter(guess_q, i);
        cur_green  = green_q[i];
      end
    end
  end

  wordle_letter_match u_match (
    .letter_i   (cur_letter),
    .answer_i   (answer_q),
    .used_i     (used_q),
    .hit_o      (hit),
    .consumed_o (consumed)
  );

  assign row_inc = (row_q == 3'(MAX_GUESSES)) ? row_q : row_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    answer_d = answer_q;
    green_d  = green_q;
    used_d   = used_q;
    work_d   = work_q;
    idx_d    = idx_q;
    colors_d = colors_q;
    row_d    = row_q;
    win_d    = win_q;
    lose_d   = lose_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !win_q && !lose_q) begin
          guess_d  = guess_i;
          answer_d = answer_i;
          state_d  = ST_GREEN;
        end
      end
      ST_GREEN: begin
        for (int i = 0; i < WORD_LEN; i++) begin
          green_d[i] = (get_letter(guess_q, i) == get_letter(answer_q, i));
          work_d[(WORD_LEN-1-i)*2 +: 2] = green_d[i] ? COL_GREEN : COL_GRAY;
        end
        used_d  = green_d;
        idx_d   = 3'd0;
        state_d = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (!cur_green && hit) begin
          for (int i = 0; i < WORD_LEN; i++) begin
            if (idx_q == 3'(i)) work_d[(WORD_LEN-1-i)*2 +: 2] = COL_YELLOW;
          end
          used_d = used_q | consumed;
        end
        // Results are registered on the way into DONE so they are visible alongside the done pulse.
        if (idx_q == 3'(WORD_LEN - 1)) begin
          state_d  = ST_DONE;
          colors_d = work_d;
          row_d    = row_inc;
          win_d    = &green_q;
          lose_d   = (row_inc == 3'(MAX_GUESSES)) && !(&green_q);
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clear_i) begin
      state_d  = ST_IDLE;
      colors_d = '0;
      row_d    = '0;
      win_d    = 1'b0;
      lose_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      guess_q  <= '0;
      answer_q <= '0;
      green_q  <= '0;
      used_q   <= '0;
      work_q   <= '0;
      idx_q    <= '0;
      colors_q <= '0;
      row_q    <= '0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      answer_q <= answer_d;
      green_q  <= green_d;
      used_q   <= used_d;
      work_q   <= work_d;
      idx_q    <= idx_d;
      colors_q <= colors_d;
      row_q    <= row_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign colors_o  = colors_q;
  assign row_idx_o = row_q;
  assign win_o     = win_q;
  assign lose_o    = lose_q;

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// tb/tb_wordle_guess_scorer.sv - scoreboard bench with directed guess/answer vectors
module tb_wordle_guess_scorer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [39:0] guess_i = '0;
  logic [39:0] answer_i = '0;
  logic        busy_o, done_o, win_o, lose_o;
  logic [9:0]  colors_o;
  logic [2:0]  row_idx_o;

  typedef struct packed {
    logic [9:0]  colors;
    logic [2:0]  row;
    logic        win;
    logic        lose;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  wordle_guess_scorer dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (clear_i),
    .start_i   (start_i),
    .guess_i   (guess_i),
    .answer_i  (answer_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .colors_o  (colors_o),
    .row_idx_o (row_idx_o),
    .win_o     (win_o),
    .lose_o    (lose_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("colors", 32'(colors_o), 32'(e.colors));
        chk("row_idx", 32'(row_idx_o), 32'(e.row));
        chk("win", 32'(win_o), 32'(e.win));
        chk("lose", 32'(lose_o), 32'(e.lose));
      end
    end
  end

  task automatic issue(input logic [39:0] g, input logic [39:0] a, input bit accept,
                       input logic [9:0] ec, input logic [2:0] er, input logic ew, input logic el);
    exp_t e;
    @(negedge clk_i);
    guess_i  = g;
    answer_i = a;
    start_i  = 1'b1;
    if (accept) begin
      e = '{colors: ec, row: er, win: ew, lose: el, cyc: cyc + 7};
      sb.push_back(e);
    end
    @(negedge clk_i);
    start_i  = 1'b0;
    guess_i  = ~g;
    answer_i = ~a;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk_i);
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
    @(negedge clk_i);
  endtask

  task automatic pulse_clear();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_colors", colors_o, 0);
    chk("rst_row", row_idx_o, 0);
    chk("rst_win", win_o, 0);
    chk("rst_lose", lose_o, 0);

    issue("CRANE", "CRANE", 1, 10'h2AA, 3'd1, 1'b1, 1'b0);
    drain();
    issue("CRANE", "CRANE", 0, 10'h0, 3'd0, 1'b0, 1'b0);
    chk("ignored_after_win_busy", busy_o, 0);
    repeat (10) @(negedge clk_i);
    chk("win_sticky", win_o, 1);

    pulse_clear();
    chk("clr_row", row_idx_o, 0);
    chk("clr_win", win_o, 0);
    chk("clr_colors", colors_o, 0);

    issue("PAPER", "APPLE", 1, 10'h164, 3'd1, 1'b0, 1'b0);
    drain();
    issue("FLOOR", "ROBOT", 1, 10'h019, 3'd2, 1'b0, 1'b0);
    drain();
    issue("EERIE", "SPEED", 1, 10'h140, 3'd3, 1'b0, 1'b0);
    drain();

    pulse_clear();
    for (int k = 1; k <= 6; k++) begin
      issue("QUILT", "CRANE", 1, 10'h000, 3'(k), 1'b0, (k == 6));
      drain();
    end
    issue("CRANE", "CRANE", 0, 10'h0, 3'd0, 1'b0, 1'b0);
    chk("ignored_after_lose_busy", busy_o, 0);
    repeat (10) @(negedge clk_i);
    chk("lose_sticky", lose_o, 1);
    pulse_clear();
    chk("clr_lose", lose_o, 0);
    chk("clr_row6", row_idx_o, 0);
    issue("NACRE", "CRANE", 1, 10'h156, 3'd1, 1'b0, 1'b0);
    drain();

    // Reset while in the yellow pass: no done, everything back to zero.
    @(negedge clk_i);
    guess_i = "TRACE"; answer_i = "CRANE"; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("mid_busy", busy_o, 1);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_colors", colors_o, 0);
    chk("midrst_row", row_idx_o, 0);
    repeat (10) @(negedge clk_i);

    // Extra start while GREEN must not produce a second result.
    @(negedge clk_i);
    guess_i = "TRACE"; answer_i = "CRANE"; start_i = 1'b1;
    sb.push_back('{colors: 10'h0A6, row: 3'd1, win: 1'b0, lose: 1'b0, cyc: cyc + 7});
    @(negedge clk_i);
    guess_i = "CRANE";
    @(negedge clk_i);
    start_i = 1'b0;
    drain();
    repeat (10) @(negedge clk_i);

    // Clear mid-scoring aborts; start coincident with clear is dropped.
    @(negedge clk_i);
    guess_i = "CRANE"; answer_i = "CRANE"; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("midclr_busy", busy_o, 0);
    chk("midclr_row", row_idx_o, 0);
    @(negedge clk_i);
    clear_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0; start_i = 1'b0;
    chk("start_with_clear_busy", busy_o, 0);
    repeat (12) @(negedge clk_i);
    chk("no_win_after_abort", win_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wordle_guess_scorer.md
Name: wordle_guess_scorer

Overview:
- Scores a submitted 5-letter guess against the secret word, producing a per-letter colour code (green/yellow/gray) with correct duplicate-letter handling.
- Sits between wordle_sm and the VGA colour logic in wordle_top. It consumes the latched guess {first_letter..fifth_letter} and randomWord, and produces tile colours plus game-level win/lose.
- Also tracks the guess row count so the renderer knows which row was just scored.

Parameters:
- LETTER_W, 8, bits per letter (ASCII).
- WORD_LEN, 5, letters per word; fixed at 5 in this revision.
- MAX_GUESSES, 6, guesses before lose asserts.

Ports:
- Clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; all state cleared on the next Clk edge.
- clear  in  1  synchronous new-game request; lower priority than reset.
- start  in  1  single-cycle request to score guess/answer.
- guess  in  40  guess word; [39:32] = letter 0 (leftmost) … [7:0] = letter 4.
- answer  in  40  secret word, same packing.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse; colors/win/lose/row_idx are valid from this cycle on.
- colors  out  10  2 bits per letter, [9:8] = letter 0; 00 = gray, 01 = yellow, 10 = green, 11 unused.
- row_idx  out  3  number of guesses scored this game (0..6); row of the last result = row_idx-1.
- win  out  1  sticky: last scored guess equals answer.
- lose  out  1  sticky: MAX_GUESSES scored without a win.

Behaviour:
- Reset values: busy=0, done=0, colors=0, row_idx=0, win=0, lose=0, FSM=IDLE.
- FSM states: IDLE, GREEN, YELLOW, DONE.
- IDLE: when start=1, win=0 and lose=0 (cycle T), latch guess/answer into internal registers and go to GREEN.
  - start while win or lose is set: ignored.
  - start while not IDLE: ignored; no queuing.
- GREEN (T+1):
  - green[i] = (g[i]==a[i]) for all i in parallel.
  - used[j] = green[j].
  - Working colour = 10 where green, else 00.
  - idx = 0, go to YELLOW.
- YELLOW (T+2..T+6): one position per cycle, idx 0..4.
  - If !green[idx]: find the lowest j with !used[j] && a[j]==g[idx]; if found, colour[idx] = 01 and used[j] = 1.
  - idx==4 goes to DONE.
- DONE (T+7):
  - done=1 for exactly this cycle.
  - colors register loaded with the working colours on entry, so it is visible in T+7.
  - row_idx increments (saturates at MAX_GUESSES).
  - win set if all five colours are green.
  - lose set if the new row_idx==MAX_GUESSES and not win.
  - Go to IDLE.
- Fixed latency: done occurs 7 cycles after the accepting start edge.
- colors, win, lose and row_idx hold until the next DONE, clear or reset.
- Duplicate rule: each answer letter satisfies at most one guess letter. Greens always consume first; yellows are assigned left to right.
- clear (reset=0):
  - row_idx, win, lose and colors go to 0; FSM goes to IDLE.
  - If clear is asserted mid-scoring, the evaluation is aborted with no done pulse.
  - start in the same cycle as clear is ignored.
- reset during any state: everything returns to reset values on the next edge; no done pulse.
- Inputs guess/answer may change after the start cycle without affecting the result.

Decomposition:
- Shared package wordle_pkg: LETTER_W, WORD_LEN, MAX_GUESSES, colour codes (COL_GRAY=2'b00, COL_YELLOW=2'b01, COL_GREEN=2'b10), and the state encodings.
- One natural sub-module: wordle_letter_match. It is combinational; inputs are one guess letter, answer, and the used mask. Outputs are hit and a one-hot consumed-position vector (lowest index wins).

Test Plan:
- answer "CRANE", guess "CRANE", start -> done at T+7, colors=10'h2AA, win=1, row_idx=1; a further start is ignored (busy stays 0).
- answer "APPLE", guess "PAPER" -> colors=10'h164 (Y,Y,G,Y,gray), win=0, row_idx=1.
- answer "ROBOT", guess "FLOOR" -> colors=10'h019 (gray,gray,Y,G,Y). The extra O is handled so greens win the duplicate.
- answer "SPEED", guess "EERIE" -> colors=10'h140 (Y,Y,gray,gray,gray). The third E is gray because the answer's Es are exhausted.
- Six non-matching guesses -> lose=1 on the 6th done, row_idx=6. A 7th start is ignored. clear -> lose=0, row_idx=0, and scoring works again.
- Mid-op events:
  - reset asserted in YELLOW -> all outputs 0 next cycle, no done.
  - start pulsed again in GREEN -> ignored; a single done at T+7.
